simon_playback: RTL and testbench
=================================

Name: simon_playback

Overview:
- Sequence playback engine: on request from the game FSM, reads the first `length` entries of the sequence ROM and shows each one as a one-hot LED flash, with a blank gap between flashes.
- Output side of the game, complementing the button-capture path. Consumes ROM reads, produces LED patterns.
- Sits between simon_fsm (start/abort/done handshake) and sequence_rom (read port). Its `led` output is muxed onto LD0–LD3 while `busy` is high.

Parameters:
- DEPTH, 4: number of ROM entries; `length` values above DEPTH are clamped to DEPTH.
- ADDR_W, 4: ROM address width.
- ON_TICKS, 2: slow_clk cycles each colour stays lit; legal range 1..15.
- GAP_TICKS, 1: slow_clk cycles of dark LEDs after each colour; legal range 1..15.

Ports:
- slow_clk  in  1  ~1 Hz game tick; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to begin playback; sampled only in IDLE.
- abort  in  1  synchronous cancel; highest priority after reset.
- length  in  ADDR_W+1  number of entries to play (0..DEPTH), sampled with start.
- rd_addr  out  ADDR_W  ROM read address (registered).
- rd_data  in  2  ROM data; valid one cycle after rd_addr changes (synchronous ROM).
- led  out  4  one-hot colour, registered: code 0 gives 4'b0001, 1 gives 4'b0010, 2 gives 4'b0100, 3 gives 4'b1000.
- busy  out  1  high in states ADDR, LATCH, SHOW and GAP.
- done  out  1  one-cycle pulse when playback completes normally.
- play_idx  out  ADDR_W  index of the entry currently being played, for the debug display.

Behaviour:
- Reset (async) values: state=IDLE, led=0, rd_addr=0, play_idx=0, busy=0, done=0, counters=0.
- States and transitions:
  - IDLE: start with clamped length L>0 → ADDR, with play_idx=0 and rd_addr=0. start with L==0 → DONE directly (done pulses, no LED activity).
  - ADDR (1 cycle): rd_addr is stable and the ROM samples it → LATCH.
  - LATCH (1 cycle): rd_data is valid; at the end of the cycle led <= onehot(rd_data) and the dwell counter loads ON_TICKS-1 → SHOW.
  - SHOW: led is held; the counter decrements each cycle; at 0, led <= 0 and the counter loads GAP_TICKS-1 → GAP.
  - GAP: led=0; at counter 0 there are two cases:
    - if play_idx==L-1 → DONE;
    - otherwise play_idx and rd_addr increment → ADDR.
  - DONE (1 cycle): done=1, busy=0 → IDLE.
- Timing: each element occupies 2+ON_TICKS+GAP_TICKS cycles. With start sampled at edge 0, element k's LED is lit on cycles 3+P·k through 2+ON_TICKS+P·k, where P=2+ON_TICKS+GAP_TICKS. done is high on cycle 1+P·L.
- Handshake rules:
  - start is ignored unless the block is in IDLE (no queuing).
  - start and abort asserted together in IDLE: abort wins and the block stays in IDLE.
  - abort in any non-IDLE state: next state is IDLE, led=0, rd_addr=0, play_idx=0, no done pulse.
- Length and addressing:
  - L is latched at start; later changes to `length` have no effect until the next start.
  - rd_addr never exceeds DEPTH-1; there is no wrap-around.
- Reset mid-playback: outputs go to reset values immediately (async); the next start begins a fresh playback.
- Counter width: 4 bits, sufficient for the legal ON_TICKS/GAP_TICKS range.

Decomposition:
- simon_pkg holds:
  - the colour codes (C_UP=0, C_LEFT=1, C_RIGHT=2, C_DOWN=3);
  - the state encoding (IDLE, ADDR, LATCH, SHOW, GAP, DONE; 3 bits);
  - the onehot4 function mapping a 2-bit code to the LED pattern.
- No sub-module: the single FSM plus one dwell counter fits in one module.

Test Plan (DEPTH=4, ON_TICKS=2, GAP_TICKS=1, so P=5; ROM preloaded with {2,0,3,1}):
- start, length=3 → led=0100 on cycles 3–4, 0001 on 8–9, 1000 on 13–14, 0 otherwise; rd_addr steps 0,1,2; done=1 only on cycle 16; busy high on cycles 1–15.
- start, length=0 → done=1 on cycle 1; busy never high; led stays 0.
- start, length=7 → clamped to 4: the four colours play in order, with 0010 on cycles 18–19 and done on cycle 21.
- abort on cycle 8 of a length-3 playback → on cycle 9 state is IDLE, led=0, rd_addr=0, and done never pulses; a new start then replays from index 0.
- start pulsed again on cycle 5 while busy → ignored, and the timing matches the first scenario; start together with abort in IDLE → stays IDLE.
- reset asserted asynchronously mid-SHOW → led, busy, rd_addr and play_idx go to 0 immediately without waiting for a clock edge; after release, a start with length=1 gives led=0100 on cycles 3–4 and done on cycle 6.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: colour codes, playback
// state encoding and the colour-to-LED mapping.
package simon_pkg;

    localparam logic [1:0] C_UP    = 2'd0;
    localparam logic [1:0] C_LEFT  = 2'd1;
    localparam logic [1:0] C_RIGHT = 2'd2;
    localparam logic [1:0] C_DOWN  = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_SHOW  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    function automatic logic [3:0] onehot4(input logic [1:0] code);
        logic [3:0] r;
        r = 4'b0000;
        case (code)
            C_UP:    r = 4'b0001;
            C_LEFT:  r = 4'b0010;
            C_RIGHT: r = 4'b0100;
            C_DOWN:  r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/simon_playback.sv
// Plays the first `length` ROM entries as one-hot LED flashes,
// each followed by a dark gap, then pulses done.
module simon_playback
    import simon_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 4,
    parameter int ON_TICKS  = 2,
    parameter int GAP_TICKS = 1
) (
    input  logic              slow_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    output logic [3:0]        led,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] play_idx
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      ON_LD   = 4'(ON_TICKS - 1);
    localparam logic [3:0]      GAP_LD  = 4'(GAP_TICKS - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        led_q, led_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   len_c;
    logic              last;

    // Clamping here keeps rd_addr inside the ROM for any request.
    assign len_c = (length > DEPTH_L) ? DEPTH_L : length;
    assign last  = ({1'b0, idx_q} == (len_q - 1'b1));

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (abort) begin
            state_d = S_IDLE;
            led_d   = 4'b0000;
            addr_d  = '0;
            idx_d   = '0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_d   = len_c;
                        addr_d  = '0;
                        idx_d   = '0;
                        state_d = (len_c == '0) ? S_DONE : S_ADDR;
                    end
                end
                S_ADDR: state_d = S_LATCH;
                S_LATCH: begin
                    led_d   = onehot4(rd_data);
                    cnt_d   = ON_LD;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt_q == 4'd0) begin
                        led_d   = 4'b0000;
                        cnt_d   = GAP_LD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            led_q   <= 4'b0000;
            addr_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign rd_addr  = addr_q;
    assign play_idx = idx_q;
    assign led      = led_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q == S_ADDR) || (state_q == S_LATCH) ||
                      (state_q == S_SHOW) || (state_q == S_GAP);

endmodule

// File: tb/tb_simon_playback.sv
// Bench for simon_playback: directed timing scenarios plus random
// start/abort/reset traffic against a cycle-count playback model.
module tb_simon_playback;

    localparam int DEPTH = 4;
    localparam int ON    = 2;
    localparam int GAP   = 1;
    localparam int P     = 2 + ON + GAP;

    logic       slow_clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] length = 5'd0;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic [3:0] led;
    logic       busy;
    logic       done;
    logic [3:0] play_idx;

    int vectors = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [1:0] rom [0:DEPTH-1];

    // Model: cycles elapsed since the accepted start edge.
    bit m_run = 1'b0;
    int m_c = 0;
    int m_L = 0;
    int m_hold = 0;

    logic [3:0] led_t  [0:31];
    logic       done_t [0:31];
    logic       busy_t [0:31];
    logic [3:0] addr_t [0:31];

    simon_playback dut (
        .slow_clk(slow_clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .length(length),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .led(led),
        .busy(busy),
        .done(done),
        .play_idx(play_idx)
    );

    always #5 slow_clk = ~slow_clk;

    always_ff @(posedge slow_clk) rd_data <= rom[rd_addr[1:0]];

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    always @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            m_run  <= 1'b0;
            m_hold <= 0;
        end else if (abort) begin
            m_run  <= 1'b0;
            m_hold <= 0;
        end else if (!m_run && start) begin
            m_L    <= (int'(length) > DEPTH) ? DEPTH : int'(length);
            m_c    <= 1;
            m_run  <= 1'b1;
            m_hold <= 0;
        end else if (m_run) begin
            m_c <= m_c + 1;
            if (m_c >= P * m_L + 1) begin
                m_run  <= 1'b0;
                m_hold <= (m_L == 0) ? 0 : m_L - 1;
            end
        end
    end

    always @(negedge slow_clk) begin
        if (chk_en && !reset) begin
            automatic int k = 0;
            automatic int ph = 0;
            automatic logic [3:0] e_led = 4'b0000;
            automatic logic e_busy = 1'b0;
            automatic logic e_done = 1'b0;
            automatic int e_addr = m_hold;
            if (m_run) begin
                if (m_c <= P * m_L) begin
                    k      = (m_c - 1) / P;
                    ph     = (m_c - 1) % P;
                    e_busy = 1'b1;
                    e_addr = k;
                    if (ph >= 2 && ph < 2 + ON)
                        e_led = 4'b0001 << rom[k];
                end else begin
                    e_done = 1'b1;
                    e_addr = (m_L == 0) ? 0 : m_L - 1;
                end
            end
            check("led", {4'h0, led}, {4'h0, e_led});
            check("busy", {7'h0, busy}, {7'h0, e_busy});
            check("done", {7'h0, done}, {7'h0, e_done});
            check("rd_addr", {4'h0, rd_addr}, 8'(e_addr));
            check("play_idx", {4'h0, play_idx}, 8'(e_addr));
        end
    end

    // Call right after a negedge; start is sampled on the next edge
    // (edge 0), and index c of the traces is cycle c.
    task automatic run(input logic [4:0] len, input int n,
                       input int restart_at, input int abort_at);
        length = len;
        start  = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge slow_clk);
            led_t[c]  = led;
            done_t[c] = done;
            busy_t[c] = busy;
            addr_t[c] = rd_addr;
            start = (c == restart_at);
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic int count_done(input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) s += int'(done_t[c]);
        return s;
    endfunction

    function automatic int count_busy(input int n);
        int s = 0;
        for (int c = 1; c <= n; c++) s += int'(busy_t[c]);
        return s;
    endfunction

    initial begin
        rom[0] = 2'd2;
        rom[1] = 2'd0;
        rom[2] = 2'd3;
        rom[3] = 2'd1;
        repeat (2) @(negedge slow_clk);
        check("rst_led", {4'h0, led}, 8'h00);
        check("rst_busy", {7'h0, busy}, 8'h00);
        check("rst_done", {7'h0, done}, 8'h00);
        check("rst_addr", {4'h0, rd_addr}, 8'h00);
        check("rst_idx", {4'h0, play_idx}, 8'h00);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge slow_clk);

        run(5'd3, 18, 5, 0);
        check("s1_led3", {4'h0, led_t[3]}, 8'h04);
        check("s1_led4", {4'h0, led_t[4]}, 8'h04);
        check("s1_led5", {4'h0, led_t[5]}, 8'h00);
        check("s1_led8", {4'h0, led_t[8]}, 8'h01);
        check("s1_led13", {4'h0, led_t[13]}, 8'h08);
        check("s1_led14", {4'h0, led_t[14]}, 8'h08);
        check("s1_addr11", {4'h0, addr_t[11]}, 8'h02);
        check("s1_done16", {7'h0, done_t[16]}, 8'h01);
        check("s1_ndone", 8'(count_done(18)), 8'd1);
        check("s1_busy1", {7'h0, busy_t[1]}, 8'h01);
        check("s1_busy15", {7'h0, busy_t[15]}, 8'h01);
        check("s1_nbusy", 8'(count_busy(18)), 8'd15);

        run(5'd0, 4, 0, 0);
        check("s0_done1", {7'h0, done_t[1]}, 8'h01);
        check("s0_nbusy", 8'(count_busy(4)), 8'd0);

        run(5'd7, 23, 0, 0);
        check("s7_led18", {4'h0, led_t[18]}, 8'h02);
        check("s7_led19", {4'h0, led_t[19]}, 8'h02);
        check("s7_addr16", {4'h0, addr_t[16]}, 8'h03);
        check("s7_done21", {7'h0, done_t[21]}, 8'h01);
        check("s7_ndone", 8'(count_done(23)), 8'd1);

        run(5'd3, 12, 0, 8);
        check("ab_led9", {4'h0, led_t[9]}, 8'h00);
        check("ab_addr9", {4'h0, addr_t[9]}, 8'h00);
        check("ab_busy9", {7'h0, busy_t[9]}, 8'h00);
        check("ab_ndone", 8'(count_done(12)), 8'd0);
        run(5'd3, 18, 0, 0);
        check("ab_replay3", {4'h0, led_t[3]}, 8'h04);
        check("ab_replay8", {4'h0, led_t[8]}, 8'h01);

        start = 1'b1;
        abort = 1'b1;
        length = 5'd2;
        @(negedge slow_clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", {7'h0, busy}, 8'h00);
        check("sa_done", {7'h0, done}, 8'h00);
        @(negedge slow_clk);
        check("sa_busy2", {7'h0, busy}, 8'h00);

        run(5'd3, 8, 0, 0);
        check("ar_pre_led", {4'h0, led}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("ar_led", {4'h0, led}, 8'h00);
        check("ar_busy", {7'h0, busy}, 8'h00);
        check("ar_addr", {4'h0, rd_addr}, 8'h00);
        check("ar_idx", {4'h0, play_idx}, 8'h00);
        @(negedge slow_clk);
        reset = 1'b0;
        run(5'd1, 8, 0, 0);
        check("ar_led3", {4'h0, led_t[3]}, 8'h04);
        check("ar_led4", {4'h0, led_t[4]}, 8'h04);
        check("ar_done5", {7'h0, done_t[5]}, 8'h00);
        check("ar_done6", {7'h0, done_t[6]}, 8'h01);

        for (int i = 0; i < DEPTH; i++) rom[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 600; i++) begin
            @(negedge slow_clk);
            reset  = ($urandom_range(0, 79) == 0);
            start  = ($urandom_range(0, 5) == 0);
            abort  = ($urandom_range(0, 29) == 0);
            length = 5'($urandom_range(0, 9));
        end
        @(negedge slow_clk);
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge slow_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
